// File: rtl/sprite_palette_ram_if.sv
// Bus bundle for the sprite palette: palette write port, bank swap control,
// pixel index input and faded colour output.
interface sprite_palette_ram_if #(
    parameter int IDX_W     = 4,
    parameter int CH_W      = 4,
    parameter int NUM_BANKS = 2
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_addr;
    logic [3*CH_W-1:0] wr_data;
    logic              swap_req;
    logic              frame_start;
    logic              pix_valid;
    logic [IDX_W-1:0]  pix_index;
    logic [CH_W-1:0]   brightness;
    logic              out_valid;
    logic [CH_W-1:0]   red;
    logic [CH_W-1:0]   green;
    logic [CH_W-1:0]   blue;
    logic              transparent;
    logic [BANK_W-1:0] active_bank;
    logic              swap_pending;

    modport master (
        output wr_en, wr_bank, wr_addr, wr_data, swap_req, frame_start,
               pix_valid, pix_index, brightness,
        input  out_valid, red, green, blue, transparent, active_bank, swap_pending
    );

    modport slave (
        input  wr_en, wr_bank, wr_addr, wr_data, swap_req, frame_start,
               pix_valid, pix_index, brightness,
        output out_valid, red, green, blue, transparent, active_bank, swap_pending
    );
endinterface

// File: rtl/sprite_palette_ram.sv
// Double-buffered sprite palette: 2-stage lookup + transparency key + brightness
// fade, with a frame-synchronous active-bank swap.
module sprite_palette_ram #(
    parameter int IDX_W      = 4,
    parameter int CH_W       = 4,
    parameter int NUM_BANKS  = 2,
    parameter int TRANSP_IDX = 0
) (
    input logic               Clk,
    input logic               Reset,
    sprite_palette_ram_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int DEPTH  = 1 << IDX_W;
    localparam int RGB_W  = 3 * CH_W;
    localparam int PROD_W = 2 * CH_W + 1;

    typedef enum logic {IDLE, PENDING} swap_state_t;

    logic [NUM_BANKS-1:0][DEPTH-1:0][RGB_W-1:0] palette;
    logic [BANK_W-1:0]    bank_q;
    swap_state_t          state, state_nxt;
    logic                 do_swap;

    logic [2:1]           vld_pipe;
    logic [RGB_W-1:0]     lookup, rgb1;
    logic                 t1, t2;
    logic [CH_W-1:0]      b1;
    logic [2:0][CH_W-1:0] faded, chan_q;

    // Palette is a flop array so reset can clear every entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)           palette <= '0;
        else if (bus.wr_en)  palette[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
    end

    // Write-first: a same-cycle write to the looked-up entry wins over stored data.
    assign lookup = (bus.wr_en && bus.wr_bank == bank_q && bus.wr_addr == bus.pix_index)
                  ? bus.wr_data : palette[bank_q][bus.pix_index];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_pipe <= '0;
            rgb1     <= '0;
            t1       <= 1'b0;
            b1       <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], bus.pix_valid};
            if (bus.pix_valid) begin
                rgb1 <= lookup;
                t1   <= (bus.pix_index == IDX_W'(TRANSP_IDX));
                b1   <= bus.brightness;
            end
        end
    end

    // Fade scales by (brightness+1)/2^CH_W so all-ones is an exact identity.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [PROD_W-1:0] prod;
        assign prod     = PROD_W'(rgb1[c*CH_W +: CH_W]) * (PROD_W'(b1) + PROD_W'(1));
        assign faded[c] = prod[2*CH_W-1:CH_W];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            chan_q <= '0;
            t2     <= 1'b0;
        end else if (vld_pipe[1]) begin
            chan_q <= faded;
            t2     <= t1;
        end
    end

    assign bus.out_valid   = vld_pipe[2];
    assign bus.red         = chan_q[2];
    assign bus.green       = chan_q[1];
    assign bus.blue        = chan_q[0];
    assign bus.transparent = t2;

    // A frame_start swaps if a request is pending or arrives on the same cycle.
    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        if (bus.frame_start && (state == PENDING || bus.swap_req)) begin
            do_swap   = 1'b1;
            state_nxt = IDLE;
        end else if (bus.swap_req) begin
            state_nxt = PENDING;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            bank_q <= '0;
        end else begin
            state <= state_nxt;
            if (do_swap) bank_q <= bank_q + BANK_W'(1);
        end
    end

    assign bus.active_bank  = bank_q;
    assign bus.swap_pending = (state == PENDING);
endmodule

// File: doc/sprite_palette_ram.md
Name: sprite_palette_ram

Overview:
Programmable, double-buffered sprite palette for the VGA colour path. It replaces fixed per-sprite palette lookup tables with a writable table of NUM_BANKS banks of 2^IDX_W RGB entries. Sprite pixel indices come from the sprite ROM stage and pass through a 2-stage pipeline that does three things: palette lookup, transparency keying, and a global brightness fade. The output feeds the colour mapper.

Parameters:
IDX_W, 4, palette index width; entries per bank = 2^IDX_W
CH_W, 4, bits per colour channel (R, G, B each)
NUM_BANKS, 2, number of palette banks (power of 2, >=2)
TRANSP_IDX, 0, index value treated as transparent

Ports:
Clk  in  1  system clock (all logic rising-edge)
Reset  in  1  asynchronous, active-high reset
wr_en  in  1  palette write strobe
wr_bank  in  $clog2(NUM_BANKS)  bank to write
wr_addr  in  IDX_W  entry to write
wr_data  in  3*CH_W  {R,G,B} to write
swap_req  in  1  pulse: request active-bank advance at next frame_start
frame_start  in  1  pulse at start of frame (vsync edge)
pix_valid  in  1  pixel index valid this cycle
pix_index  in  IDX_W  sprite pixel palette index
brightness  in  CH_W  global fade level; all-ones = full brightness
out_valid  out  1  output pixel valid
red  out  CH_W  faded red
green  out  CH_W  faded green
blue  out  CH_W  faded blue
transparent  out  1  pixel is transparent (index == TRANSP_IDX)
active_bank  out  $clog2(NUM_BANKS)  bank currently used for lookups
swap_pending  out  1  swap requested, not yet applied

Behaviour:
- Reset (async, active-high): every palette entry in every bank clears to 0. active_bank=0, swap_pending=0, out_valid=0, red=green=blue=0, transparent=0. Pipeline registers clear. Reset asserted mid-stream discards all in-flight pixels. After reset deasserts, the first valid output requires a fresh pix_valid.
- Write: when wr_en=1, entry [wr_bank][wr_addr] takes wr_data at the clock edge. Any bank may be written at any time, including the active one.
- Read-during-write: if the stage-1 lookup hits the same bank/address being written that cycle, stage 1 captures wr_data (write-first forwarding).
- Stage 1 (cycle 1): registers the following:
  - v1 = pix_valid
  - rgb1 = palette[active_bank][pix_index]
  - t1 = (pix_index == TRANSP_IDX)
  - b1 = brightness, sampled with the pixel
- Stage 2 (cycle 2), per channel c: out = (c * (b1 + 1)) >> CH_W.
  - The product is computed at 2*CH_W+1 bits; the result is truncated to CH_W bits.
  - brightness=all-ones gives identity; brightness=0 gives c>>CH_W.
  - out_valid=v1, transparent=t1.
- Latency: exactly 2 cycles from pix_valid/pix_index to out_valid/colour. Throughput is 1 pixel/cycle; there is no stall.
- When out_valid=0: red/green/blue/transparent hold their previous values. Downstream logic must qualify them with out_valid.
- Bank swap FSM, states IDLE / PENDING:
  - IDLE, swap_req=1, frame_start=0: go to PENDING; swap_pending=1.
  - PENDING, frame_start=1: active_bank <= active_bank+1 (mod NUM_BANKS); go to IDLE; swap_pending=0.
  - swap_req and frame_start in the same cycle (either state): the swap applies on that edge; the state ends IDLE.
  - swap_req while PENDING: ignored; swaps do not queue.
  - frame_start in IDLE: no effect.
- The active_bank change takes effect for lookups sampled on the cycle after the swap edge. Pixels already in stage 1 or 2 keep their old-bank colour.
- active_bank wraps from NUM_BANKS-1 to 0.

Test Plan:
1. Reset values: assert Reset mid-stream with pix_valid=1 -> same cycle, out_valid=0, colours=0, active_bank=0, swap_pending=0. After release, every read of index 5 returns 0x000.
2. Write then read, default params: write bank0[3]=0xF71; brightness=0xF; pix_index=3 -> exactly 2 cycles later out_valid=1, rgb=F,7,1, transparent=0.
3. Transparency and fade: bank0[0]=0xFFF, bank0[9]=0xE82.
   - index 0 -> transparent=1.
   - index 9 at brightness=7 -> rgb = (14*8)>>4=7, (8*8)>>4=4, (2*8)>>4=1.
   - index 9 at brightness=0 -> rgb = 0, 0, 0.
4. Read-during-write: write bank0[4]=0x5A3 in the same cycle pix_index=4 is presented -> output 0x5A3, not the old value.
5. Bank swap:
   - Set bank1[2]=0x123, bank0[2]=0xABC; stream index 2 continuously.
   - Pulse swap_req -> swap_pending=1; output stays 0xABC.
   - Pulse frame_start -> active_bank=1; the first 0x123 appears 3 cycles after the frame_start edge.
   - A second swap on the next frame_start wraps active_bank to 0.
6. Simultaneous/duplicate requests:
   - swap_req and frame_start on the same cycle -> immediate swap, swap_pending stays 0.
   - Two swap_req pulses before one frame_start -> exactly one bank advance.
